// File: rtl/bkram_ctrl.sv
// bkram_ctrl: backup-RAM sequencer that moves the NVRAM buffer to and from SD sectors, one handshake per sector.
// Define BKRAM_AUTOSAVE_EN to build NVRAM dirty tracking (bk_pending) and the OSD-triggered autosave.
module bkram_ctrl #(
    parameter int SECTORS = 64
) (
    input  logic        clk_sys_i,
    input  logic        reset_i,
    input  logic        cart_download_i,
    input  logic        img_mounted_i,
    input  logic        img_readonly_i,
    input  logic [63:0] img_size_i,
    input  logic        osd_status_i,
    input  logic        autosave_i,
    input  logic        bk_load_i,
    input  logic        bk_save_i,
    input  logic        nvram_we_i,
    input  logic        sd_ack_i,
    output logic [31:0] sd_lba_o,
    output logic        sd_rd_o,
    output logic        sd_wr_o,
    output logic        bk_ena_o,
    output logic        bk_loading_o,
    output logic        bk_busy_o,
    output logic        bk_pending_o
);

    localparam int CNT_W = $clog2(SECTORS);
    localparam logic [CNT_W-1:0] LAST_LBA = CNT_W'(SECTORS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_LO,
        DRAIN
    } state_e;

    state_e           state_q;
    logic             load_dir_q;
    logic [CNT_W-1:0] lba_q;
    logic             sd_rd_q;
    logic             sd_wr_q;
    logic             busy_q;
    logic             loading_q;
    logic             bk_ena_q;
    logic             bk_ena_d;
    logic             pending_q;

    logic             old_download_q;
    logic             old_load_q;
    logic             old_save_q;
    logic             old_ack_q;

    logic             download_rise;
    logic             download_fall;
    logic             ack_rise;
    logic             ack_fall;
    logic             trig_autoload;
    logic             trig_load;
    logic             trig_save;
    logic             trig_autosave;
    logic             trig_any;
    logic             trig_dir;

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            old_download_q <= 1'b0;
            old_load_q     <= 1'b0;
            old_save_q     <= 1'b0;
            old_ack_q      <= 1'b0;
        end else begin
            old_download_q <= cart_download_i;
            old_load_q     <= bk_load_i;
            old_save_q     <= bk_save_i;
            old_ack_q      <= sd_ack_i;
        end
    end

    assign download_rise = cart_download_i & ~old_download_q;
    assign download_fall = ~cart_download_i & old_download_q;
    assign ack_rise      = sd_ack_i & ~old_ack_q;
    assign ack_fall      = ~sd_ack_i & old_ack_q;

    // Autoload outranks a manual load, which outranks either save; direction 1 means read from SD.
    assign trig_autoload = bk_ena_q & download_fall & (img_size_i != 64'd0);
    assign trig_load     = bk_ena_q & bk_load_i & ~old_load_q;
    assign trig_save     = bk_ena_q & bk_save_i & ~old_save_q;
    assign trig_any      = trig_autoload | trig_load | trig_save | trig_autosave;
    assign trig_dir      = trig_autoload | trig_load;

    // A new download unbinds the image, but a mount seen during that same cycle rebinds it.
    always_comb begin
        bk_ena_d = bk_ena_q;
        if (download_rise) begin
            bk_ena_d = 1'b0;
        end
        if (cart_download_i & img_mounted_i & ~img_readonly_i) begin
            bk_ena_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            bk_ena_q <= 1'b0;
        end else begin
            bk_ena_q <= bk_ena_d;
        end
    end

`ifdef BKRAM_AUTOSAVE_EN
    logic old_as_q;
    logic as_cond;
    logic pending_d;
    logic start_xfer;

    assign as_cond       = autosave_i & pending_q & osd_status_i;
    assign trig_autosave = bk_ena_q & as_cond & ~old_as_q;
    assign start_xfer    = (state_q == IDLE) & trig_any;

    // Starting any transfer cleans the buffer, even against a game write in the same cycle.
    always_comb begin
        pending_d = pending_q;
        if (bk_ena_q & ~osd_status_i & nvram_we_i) begin
            pending_d = 1'b1;
        end
        if (start_xfer) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            old_as_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            old_as_q  <= as_cond;
            pending_q <= pending_d;
        end
    end
`else
    logic unused_autosave_inputs;

    assign unused_autosave_inputs = autosave_i ^ osd_status_i ^ nvram_we_i;
    assign trig_autosave          = 1'b0;
    assign pending_q              = 1'b0;
`endif

    // Requests and busy flags follow the state one cycle late, so a finished transfer drops busy in IDLE.
    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            load_dir_q <= 1'b0;
            lba_q      <= '0;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            busy_q     <= 1'b0;
            loading_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sd_rd_q   <= 1'b0;
                    sd_wr_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    loading_q <= 1'b0;
                    if (trig_any) begin
                        state_q    <= REQ;
                        load_dir_q <= trig_dir;
                        lba_q      <= '0;
                        busy_q     <= 1'b1;
                        loading_q  <= trig_dir;
                    end
                end
                REQ: begin
                    if (download_rise) begin
                        state_q <= DRAIN;
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                    end else begin
                        sd_rd_q <= load_dir_q;
                        sd_wr_q <= ~load_dir_q;
                        if (ack_rise) begin
                            state_q <= WAIT_LO;
                        end
                    end
                end
                WAIT_LO: begin
                    sd_rd_q <= 1'b0;
                    sd_wr_q <= 1'b0;
                    if (download_rise) begin
                        state_q <= DRAIN;
                    end else if (ack_fall) begin
                        if (lba_q == LAST_LBA) begin
                            state_q <= IDLE;
                        end else begin
                            lba_q   <= lba_q + CNT_W'(1);
                            state_q <= REQ;
                        end
                    end
                end
                DRAIN: begin
                    sd_rd_q <= 1'b0;
                    sd_wr_q <= 1'b0;
                    if (!sd_ack_i) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        loading_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sd_lba_o     = 32'(lba_q);
    assign sd_rd_o      = sd_rd_q;
    assign sd_wr_o      = sd_wr_q;
    assign bk_ena_o     = bk_ena_q;
    assign bk_loading_o = loading_q;
    assign bk_busy_o    = busy_q;
    assign bk_pending_o = pending_q;

endmodule

// File: doc/bkram_ctrl.md
# bkram_ctrl

Backup-RAM transfer sequencer between the cartridge NVRAM dual-port buffer and the HPS SD sector interface. It turns OSD load/save commands, the auto-load after a cartridge download, and the OSD-triggered autosave into sector-by-sector `sd_rd`/`sd_wr` handshakes. It drives `sd_lba`, which also forms the upper address bits of the NVRAM buffer's SD-side port. It sits in the core top level beside `hps_io`, and its `bk_loading` output is ORed into system reset.

## Interface
- `SECTORS`, default 64: number of 512-byte sectors per transfer; power of two, 2..256.
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cart_download` in 1: cartridge ROM download active (level).
- `img_mounted` in 1: save image mounted, single-cycle pulse.
- `img_readonly` in 1: the mounted image is read-only.
- `img_size` in 64: size of the mounted save image in bytes.
- `osd_status` in 1: OSD menu open (level).
- `autosave` in 1: autosave option enabled (level).
- `bk_load` in 1: manual load command (level; rising edge acts).
- `bk_save` in 1: manual save command (level; rising edge acts).
- `nvram_we` in 1: game write strobe into NVRAM.
- `sd_ack` in 1: HPS sector acknowledge.
- `sd_lba` out 32: current sector number.
- `sd_rd` out 1: sector read request.
- `sd_wr` out 1: sector write request.
- `bk_ena` out 1: a writable save image is bound to the current cartridge.
- `bk_loading` out 1: a load transfer is in progress.
- `bk_busy` out 1: any transfer is in progress.
- `bk_pending` out 1: NVRAM is dirty since the last transfer.

## Operation
- All outputs reset to 0.
- `bk_ena` register:
  - Cleared on the rising edge of `cart_download`.
  - Set when `cart_download & img_mounted & ~img_readonly`.
  - A clear and a set in the same cycle: set wins.
- Triggers. Each is a rising edge detected against a 1-cycle registered copy. All triggers are gated by `bk_ena` and are ignored unless the FSM is in IDLE.
  - LOAD: `bk_load` rising.
  - SAVE: `bk_save` rising.
  - AUTOLOAD: falling edge of `cart_download` with `img_size != 0`.
  - AUTOSAVE: rising edge of `autosave & bk_pending & osd_status`.
  - Priority: AUTOLOAD > LOAD > SAVE/AUTOSAVE.
- FSM states:
  - IDLE → REQ on a trigger. In the same cycle: latch direction, set `sd_lba` to 0, set `bk_busy`, and set `bk_loading` = direction.
  - REQ: `sd_rd` = load, `sd_wr` = ~load. Leave for WAIT_LO on the `sd_ack` rising edge, which also clears `sd_rd` and `sd_wr`.
  - WAIT_LO: on the `sd_ack` falling edge, go to IDLE if `sd_lba == SECTORS-1`, clearing `bk_busy` and `bk_loading`. Otherwise increment `sd_lba` and return to REQ.
  - DRAIN: entered from REQ or WAIT_LO on the rising edge of `cart_download`. Clears `sd_rd` and `sd_wr` at once. Moves to IDLE after `sd_ack` has been sampled low, clearing `bk_busy` and `bk_loading`.
- `sd_lba` arithmetic:
  - Only bits `[$clog2(SECTORS)-1:0]` count; the upper bits stay 0.
  - The counter never wraps, because the terminal sector ends the transfer.
- `bk_pending`:
  - Set when `bk_ena & ~osd_status & nvram_we`.
  - Cleared on IDLE→REQ for any direction.
  - A set and a clear in the same cycle: the clear wins.

## Timing
- Trigger input edge at cycle N: the edge register sees it at N+1, and `sd_rd`/`sd_wr` is high from N+2.
- `sd_ack` rising at cycle M: `sd_rd`/`sd_wr` is low from M+2, because of the registered `old_ack` plus the registered outputs.
- `sd_ack` falling at cycle K: the next request, with `sd_lba+1`, is high from K+2. On the last sector, `bk_busy`/`bk_loading` are low from K+2.
- Triggers arriving during REQ, WAIT_LO or DRAIN are dropped, not queued.
- `sd_ack` already high on entry to REQ does not count as a rising edge; the FSM waits for a fresh 0→1.
- Asynchronous `reset` mid-transfer returns the FSM to IDLE with all outputs 0. `bk_ena` is also cleared.

## Configuration
- `BKRAM_AUTOSAVE_EN`:
  - Defined: the `bk_pending` tracking and the AUTOSAVE trigger are built as described above.
  - Undefined: `bk_pending` is tied to 0, the AUTOSAVE trigger does not exist, and `autosave`, `osd_status` and `nvram_we` are unused.
  - LOAD, SAVE and AUTOLOAD behave identically in both builds.

## Test plan
- Download with `img_mounted` and `img_size`=32768, then `cart_download` falls → 64 read sectors, `sd_lba` 0..63, `bk_loading` high throughout, low 2 cycles after the 64th `sd_ack` fall.
- `bk_save` rising with `bk_ena`=1 → 64 `sd_wr` requests, `sd_rd` never high, `bk_loading` stays 0.
- `img_readonly`=1 at mount, then `bk_load` rising → `bk_ena`=0, and `sd_rd`/`sd_wr` stay 0 for 1000 cycles.
- `nvram_we` pulse with OSD closed → `bk_pending`=1. Then `autosave`=1 and `osd_status` rises → save starts and `bk_pending`=0 the cycle after IDLE→REQ. With the macro undefined → no transfer.
- `cart_download` rises during sector 10 with `sd_ack` high → `sd_wr` low at once, IDLE 1 cycle after `sd_ack` drops, `bk_busy`=0.
- `bk_load` and `bk_save` rise in the same cycle → read transfer. Async `reset` pulse mid-sector → all outputs 0 in the same cycle.
